// File: rtl/pulp_cluster_package.sv
// Shared core-side data bus types for the cluster peripheral path.
// Also carries the default outstanding-transaction depth.
package pulp_cluster_package;

  localparam int unsigned CorePeriphArbMaxOutstanding = 2;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;

endpackage

// File: rtl/core_periph_arbiter_if.sv
// Bundle of the per-core and shared-port buses around the arbiter.
// master: cores plus peripheral side; slave: the arbiter itself.
interface core_periph_arbiter_if
  import pulp_cluster_package::*;
#(
  parameter int unsigned NumReq = 8
);

  core_data_req_t req [NumReq];
  core_data_rsp_t rsp [NumReq];
  core_data_req_t slv_req;
  core_data_rsp_t slv_rsp;
  logic           err;

  modport master (
    output req, slv_rsp,
    input  rsp, slv_req, err
  );

  modport slave (
    input  req, slv_rsp,
    output rsp, slv_req, err
  );

endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the ids of granted transactions.
// Synchronous active-high reset; push is ignored when full, pop when empty.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [2**PtrW];
  logic [PtrW-1:0]       wr_q, wr_d;
  logic [PtrW-1:0]       rd_q, rd_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = inc(wr_q);
    if (do_pop)  rd_d = inc(rd_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/core_periph_arbiter.sv
// Round-robin arbiter funnelling N core data ports onto one peripheral
// port, with request lock until grant and in-order response routing.
module core_periph_arbiter
  import pulp_cluster_package::*;
#(
  parameter int unsigned NumReq         = 8,
  parameter int unsigned MaxOutstanding = CorePeriphArbMaxOutstanding
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  core_data_req_t req_i [NumReq],
  output core_data_rsp_t rsp_o [NumReq],
  output core_data_req_t slv_req_o,
  input  core_data_rsp_t slv_rsp_i,
  output logic           err_o
);

  localparam int unsigned IdW = $clog2(NumReq);

  logic [IdW-1:0] rr_q, rr_d;
  logic [IdW-1:0] lock_sel_q, lock_sel_d;
  logic           lock_q, lock_d;
  logic [IdW-1:0] sel, idx, head;
  logic           full, empty;
  logic           active, hs, pop;

  // Descending walk so the closest requester to rr_q wins last.
  always_comb begin
    sel = rr_q;
    idx = '0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        idx = IdW'((32'(rr_q) + (NumReq - 1 - i)) % NumReq);
        if (req_i[idx].req) sel = idx;
      end
    end
  end

  assign active = ~rst_i & ~full;

  always_comb begin
    slv_req_o     = req_i[sel];
    slv_req_o.req = req_i[sel].req & active;
    hs            = slv_req_o.req & slv_rsp_i.gnt;
    pop           = slv_rsp_i.r_valid & ~empty & ~rst_i;
    err_o         = slv_rsp_i.r_valid & empty & ~rst_i;
    for (int k = 0; k < NumReq; k++) begin
      rsp_o[k].gnt     = active & slv_rsp_i.gnt & (sel == IdW'(k));
      rsp_o[k].r_data  = slv_rsp_i.r_data;
      rsp_o[k].r_valid = pop & (head == IdW'(k));
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (hs) begin
      rr_d   = (sel == IdW'(NumReq - 1)) ? '0 : sel + IdW'(1);
      lock_d = 1'b0;
    end else if (slv_req_o.req) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  fifo_v3 #(
    .DATA_WIDTH (IdW),
    .DEPTH      (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (sel),
    .push_i  (hs),
    .data_o  (head),
    .pop_i   (pop)
  );

endmodule

// File: doc/core_periph_arbiter.md
CORE_PERIPH_ARBITER -- requirements
Module: core_periph_arbiter

Interface
REQ-001: Parameter NumReq, default 8: number of requesting cores; legal range 2..16.
REQ-002: Parameter MaxOutstanding, default 2: maximum granted-but-unanswered transactions; legal range 1..8.
REQ-003: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_i  input  1  reset, synchronous, active-high.
REQ-005: req_i  input  NumReq x core_data_req_t (70 bits each)  per-core request: req, add, we, data, be.
REQ-006: rsp_o  output  NumReq x core_data_rsp_t (34 bits each)  per-core response: gnt, r_data, r_valid.
REQ-007: slv_req_o  output  core_data_req_t  request to the single shared peripheral port.
REQ-008: slv_rsp_i  input  core_data_rsp_t  response from the shared peripheral port.
REQ-009: err_o  output  1  one-cycle pulse when slv_rsp_i.r_valid arrives with no transaction outstanding.

Function
REQ-010: Selection SHALL be round-robin: choose the lowest index k with req_i[k].req=1, searching cyclically from rr_ptr.
REQ-011: While the outstanding count equals MaxOutstanding, slv_req_o.req SHALL be 0 and no rsp_o[k].gnt SHALL assert, even if a response pops in the same cycle.
REQ-012: Otherwise slv_req_o SHALL equal req_i[sel] combinationally, and rsp_o[sel].gnt SHALL equal slv_rsp_i.gnt.
REQ-013: rsp_o[k].gnt SHALL be 0 for every k other than sel.
REQ-014: Lock: if slv_req_o.req=1 and slv_rsp_i.gnt=0, the arbiter SHALL store sel and keep it selected until handshake, regardless of other requests.
REQ-015: Handshake (slv_req_o.req & slv_rsp_i.gnt) SHALL release the lock, set rr_ptr to (sel+1) mod NumReq, and push sel into the ID FIFO.
REQ-016: rr_ptr SHALL change only on handshake.
REQ-017: On slv_rsp_i.r_valid=1 with the FIFO non-empty, the arbiter SHALL pop the head and assert rsp_o[head].r_valid for that cycle only.
REQ-018: slv_rsp_i.r_data SHALL be broadcast to every rsp_o[k].r_data; r_valid qualifies it.
REQ-019: On r_valid=1 with the FIFO empty (a same-cycle push does not count), nothing SHALL be popped, no rsp_o r_valid SHALL assert, and err_o SHALL pulse.
REQ-020: A push and a pop in the same cycle SHALL leave the count unchanged; the FIFO SHALL preserve grant order.
REQ-021: Minimum latency SHALL be 0 cycles from request to gnt, and r_valid SHALL pass through in the same cycle.

Reset
REQ-022: While rst_i=1: rr_ptr=0, lock cleared, FIFO empty, count 0, err_o=0, every rsp_o gnt/r_valid=0, and slv_req_o.req=0.
REQ-023: Transactions outstanding at reset SHALL be discarded; their later r_valid SHALL be treated as spurious (REQ-019).

Structure
REQ-024: core_data_req_t and core_data_rsp_t SHALL come from pulp_cluster_package; a new package constant CorePeriphArbMaxOutstanding = 2 SHALL supply the default.
REQ-025: The ID FIFO (width $clog2(NumReq), depth MaxOutstanding) SHALL be the single sub-module, instantiated as fifo_v3 from common_cells.
REQ-026: Arbitration, lock and pointer logic SHALL stay flat in core_periph_arbiter.

Verification
REQ-027: Cores 0, 3 and 5 request continuously, slave gnt=1, r_valid 1 cycle later -> grant order 0,3,5,0,3,5 and each r_valid is routed to the matching core.
REQ-028: Core 5 requests, gnt held low 4 cycles, core 2 raises req in cycle 2 -> slv_req_o stays equal to core 5's request until gnt, and core 2 is granted next.
REQ-029: MaxOutstanding=2, two handshakes, no r_valid -> slv_req_o.req=0 while full; a single r_valid pop allows exactly one further grant on the next cycle.
REQ-030: r_valid with count 0 -> err_o=1 for 1 cycle and all rsp_o r_valid=0.
REQ-031: rst_i asserted with 2 outstanding, then 2 r_valid after release -> two err_o pulses, no core r_valid, and the first grant after reset goes to core 0 if it requests.
